// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder: one digit pair per clock, LSD first, carry held between digits.
// Latency: Done pulses DIGITS+1 cycles after Start is presented; one op per DIGITS+2 cycles.
// Backpressure: none; Start is sampled only in IDLE and dropped otherwise.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   Result,
    output logic                  Cout,
    output logic                  Invalid
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [DIGITS-1:0][3:0]  a_in, b_in;
    logic [DIGITS-1:0][3:0]  a_reg, b_reg, res_reg;
    logic                    carry;
    logic [CW-1:0]           cnt;
    logic                    last;
    logic                    in_invalid;
    logic [3:0]              dig_a, dig_b, dig_sum;
    logic [4:0]              dig_raw;
    logic                    dig_carry;
    logic                    accept;

    assign a_in   = A;
    assign b_in   = B;
    assign Result = res_reg;
    assign last   = (cnt == CW'(DIGITS - 1));
    assign accept = (state == IDLE) && Start;

    always_comb begin
        in_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_in[i] > 4'd9 || b_in[i] > 4'd9) begin
                in_invalid = 1'b1;
            end
        end
    end

    // Single-digit BCD add; out-of-range digits take the same +6 correction.
    always_comb begin
        dig_a     = a_reg[cnt];
        dig_b     = b_reg[cnt];
        dig_raw   = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry};
        dig_carry = (dig_raw > 5'd9);
        dig_sum   = dig_carry ? (dig_raw[3:0] + 4'd6) : dig_raw[3:0];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == RUN);
        Done = (state == DONE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            Cout    <= 1'b0;
            Invalid <= 1'b0;
        end else if (accept) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            res_reg <= '0;
            carry   <= Cin;
            cnt     <= '0;
            Cout    <= 1'b0;
            Invalid <= in_invalid;
        end else if (state == RUN) begin
            res_reg[cnt] <= dig_sum;
            carry        <= dig_carry;
            cnt          <= cnt + CW'(1);
            if (last) begin
                Cout <= dig_carry;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4) with hand-computed sums.
module tb_bcd_serial_adder;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        Cout;
    logic        Invalid;

    int n_pass;
    int n_total;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .A(A), .B(B), .Cin(Cin),
        .Busy(Busy), .Done(Done), .Result(Result), .Cout(Cout), .Invalid(Invalid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Presents an operation and returns just after the accept edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic c);
        A = a; B = b; Cin = c; Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Counts edges until Done (bounded); busy_cnt includes the current sample.
    task automatic wait_done(output int edges, output int busy_cnt, output bit seen);
        seen = 1'b0; edges = 0; busy_cnt = Busy ? 1 : 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            edges++;
            if (Done) seen = 1'b1;
            else if (Busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else n_pass++;
        n_total++; if (Done !== 1'b0) $display("FAIL reset_done got %b want 0", Done); else n_pass++;
        n_total++; if (Result !== 16'h0000) $display("FAIL reset_result got %h want 0000", Result); else n_pass++;
        n_total++; if (Cout !== 1'b0) $display("FAIL reset_cout got %b want 0", Cout); else n_pass++;
        n_total++; if (Invalid !== 1'b0) $display("FAIL reset_invalid got %b want 0", Invalid); else n_pass++;
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int e, bc; bit s;
        start_op(16'h0007, 16'h0008, 1'b0);
        n_total++; if (Busy !== 1'b1) $display("FAIL basic_busy_at_accept got %b want 1", Busy); else n_pass++;
        wait_done(e, bc, s);
        n_total++; if (!s) $display("FAIL basic_done_timeout got none want pulse"); else n_pass++;
        n_total++; if (e !== 4) $display("FAIL basic_done_latency got %0d edges want 4", e); else n_pass++;
        n_total++; if (bc !== 4) $display("FAIL basic_busy_cycles got %0d want 4", bc); else n_pass++;
        n_total++; if (Result !== 16'h0015) $display("FAIL basic_result got %h want 0015", Result); else n_pass++;
        n_total++; if (Cout !== 1'b0) $display("FAIL basic_cout got %b want 0", Cout); else n_pass++;
        n_total++; if (Invalid !== 1'b0) $display("FAIL basic_invalid got %b want 0", Invalid); else n_pass++;
        n_total++; if (Busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", Busy); else n_pass++;
        tick();
        n_total++; if (Done !== 1'b0) $display("FAIL basic_done_width got %b want 0", Done); else n_pass++;
        tick();
        n_total++; if (Result !== 16'h0015) $display("FAIL basic_result_hold got %h want 0015", Result); else n_pass++;
    endtask

    task automatic test_digit_timing();
        logic [15:0] exp_res [4];
        exp_res[0] = 16'h0005; exp_res[1] = 16'h0045; exp_res[2] = 16'h0345; exp_res[3] = 16'h2345;
        start_op(16'h1234, 16'h1111, 1'b0);
        n_total++; if (Result !== 16'h0000) $display("FAIL digit_cleared got %h want 0000", Result); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (Result !== exp_res[i]) $display("FAIL digit_step%0d got %h want %h", i, Result, exp_res[i]);
            else n_pass++;
        end
        n_total++; if (Done !== 1'b1) $display("FAIL digit_done got %b want 1", Done); else n_pass++;
        tick();
    endtask

    task automatic test_ripple();
        int e, bc; bit s;
        start_op(16'h9999, 16'h0001, 1'b0);
        wait_done(e, bc, s);
        n_total++; if (!s) $display("FAIL ripple_done_timeout got none want pulse"); else n_pass++;
        n_total++; if (Result !== 16'h0000) $display("FAIL ripple_result got %h want 0000", Result); else n_pass++;
        n_total++; if (Cout !== 1'b1) $display("FAIL ripple_cout got %b want 1", Cout); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int e, bc; bit s; bit acc;
        start_op(16'h9999, 16'h9999, 1'b1);
        wait_done(e, bc, s);
        n_total++; if (!s) $display("FAIL b2b_first_timeout got none want pulse"); else n_pass++;
        n_total++; if (Result !== 16'h9999) $display("FAIL b2b_first_result got %h want 9999", Result); else n_pass++;
        n_total++; if (Cout !== 1'b1) $display("FAIL b2b_first_cout got %b want 1", Cout); else n_pass++;
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; Start = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            tick();
            if (Busy) acc = 1'b1;
        end
        Start = 1'b0;
        n_total++; if (!acc) $display("FAIL b2b_second_accept got idle want busy"); else n_pass++;
        wait_done(e, bc, s);
        n_total++; if (!s) $display("FAIL b2b_second_timeout got none want pulse"); else n_pass++;
        n_total++; if (Result !== 16'h5555) $display("FAIL b2b_second_result got %h want 5555", Result); else n_pass++;
        n_total++; if (Cout !== 1'b0) $display("FAIL b2b_second_cout got %b want 0", Cout); else n_pass++;
        tick();
    endtask

    task automatic test_start_ignored();
        int dones; logic [15:0] res_at_done;
        dones = 0; res_at_done = 16'hxxxx;
        start_op(16'h0007, 16'h0008, 1'b0);
        tick();
        A = 16'h1111; B = 16'h1111; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (Done) begin
                dones++;
                res_at_done = Result;
            end
            tick();
        end
        n_total++; if (dones !== 1) $display("FAIL ignore_done_count got %0d want 1", dones); else n_pass++;
        n_total++; if (res_at_done !== 16'h0015) $display("FAIL ignore_result got %h want 0015", res_at_done); else n_pass++;
        n_total++; if (Busy !== 1'b0) $display("FAIL ignore_idle_after got busy=%b want 0", Busy); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int dones; int e, bc; bit s;
        dones = 0;
        start_op(16'h1234, 16'h1111, 1'b0);
        tick();
        n_total++; if (Result !== 16'h0005) $display("FAIL abort_pre_result got %h want 0005", Result); else n_pass++;
        Rst = 1'b1;
        #1;
        n_total++; if (Busy !== 1'b0) $display("FAIL abort_busy got %b want 0", Busy); else n_pass++;
        n_total++; if (Result !== 16'h0000) $display("FAIL abort_result got %h want 0000", Result); else n_pass++;
        n_total++; if (Done !== 1'b0) $display("FAIL abort_done got %b want 0", Done); else n_pass++;
        tick();
        tick();
        Rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Done) dones++;
        end
        n_total++; if (dones !== 0) $display("FAIL abort_no_done got %0d pulses want 0", dones); else n_pass++;
        start_op(16'h0050, 16'h0050, 1'b0);
        wait_done(e, bc, s);
        n_total++; if (!s) $display("FAIL abort_next_timeout got none want pulse"); else n_pass++;
        n_total++; if (Result !== 16'h0100) $display("FAIL abort_next_result got %h want 0100", Result); else n_pass++;
        n_total++; if (Cout !== 1'b0) $display("FAIL abort_next_cout got %b want 0", Cout); else n_pass++;
        tick();
    endtask

    task automatic test_invalid();
        int e, bc; bit s;
        start_op(16'h000A, 16'h0000, 1'b0);
        n_total++; if (Invalid !== 1'b1) $display("FAIL invalid_at_accept got %b want 1", Invalid); else n_pass++;
        wait_done(e, bc, s);
        n_total++; if (!s) $display("FAIL invalid_done_timeout got none want pulse"); else n_pass++;
        n_total++; if (Result !== 16'h0010) $display("FAIL invalid_result got %h want 0010", Result); else n_pass++;
        n_total++; if (Invalid !== 1'b1) $display("FAIL invalid_at_done got %b want 1", Invalid); else n_pass++;
        tick();
        tick();
        n_total++; if (Invalid !== 1'b1) $display("FAIL invalid_hold got %b want 1", Invalid); else n_pass++;
        start_op(16'h0001, 16'h0001, 1'b0);
        n_total++; if (Invalid !== 1'b0) $display("FAIL invalid_clear got %b want 0", Invalid); else n_pass++;
        wait_done(e, bc, s);
        n_total++; if (Result !== 16'h0002) $display("FAIL invalid_next_result got %h want 0002", Result); else n_pass++;
        tick();
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        Rst = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        test_reset();
        test_basic();
        test_digit_timing();
        test_ripple();
        test_back_to_back();
        test_start_ignored();
        test_reset_abort();
        test_invalid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
